// File: rtl/onebc_seq.sv
// ROM-driven 1-bit sequencer: test one input bit, write one output bit, branch. The return stack exists only with ONEBC_SEQ_STACK_EN.
// Latency: one instruction per clock. imem_adr_o is combinational from ins_i, and outputs update on the edge that ends the instruction.
// Backpressure: en_i=0 freezes all state and re-presents pc_q, so the memory re-fetches the same instruction.
module onebc_seq #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    localparam int ISW  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
    localparam int OSW  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int SPW  = $clog2(DEPTH + 1),
    localparam int IW   = 3 + OSW + ISW + 2 * AW
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             en_i,
    input  logic [N_IN-1:0]  ins_i,
    output logic [N_OUT-1:0] outs_o,
    output logic [AW-1:0]    imem_adr_o,
    input  logic [IW-1:0]    imem_dat_i,
    output logic [SPW-1:0]   sp_o,
    output logic             ovf_o,
    output logic             unf_o
);

    typedef enum logic [1:0] {
        OP_BR   = 2'b00,
        OP_CALL = 2'b01,
        OP_RET  = 2'b10,
        OP_TOG  = 2'b11
    } op_e;

    localparam logic [ISW:0] NIN_L  = (ISW + 1)'(N_IN);
    localparam logic [OSW:0] NOUT_L = (OSW + 1)'(N_OUT);

    op_e            op;
    logic           dato;
    logic [OSW-1:0] osel;
    logic [ISW-1:0] isel;
    logic [AW-1:0]  tadr;
    logic [AW-1:0]  fadr;

    assign op   = op_e'(imem_dat_i[IW-1 -: 2]);
    assign dato = imem_dat_i[IW-3];
    assign osel = imem_dat_i[2*AW+ISW +: OSW];
    assign isel = imem_dat_i[2*AW +: ISW];
    assign tadr = imem_dat_i[AW +: AW];
    assign fadr = imem_dat_i[0 +: AW];

    // Out-of-range selects read as 0 / write nothing when N_IN or N_OUT is not a power of two.
    logic dati;
    always_comb begin
        dati = 1'b0;
        if ({1'b0, isel} < NIN_L) begin
            dati = ins_i[isel];
        end
    end

    logic [N_OUT-1:0] outs_q;
    logic [N_OUT-1:0] outs_d;
    always_comb begin
        outs_d = outs_q;
        if ({1'b0, osel} < NOUT_L) begin
            outs_d[osel] = (op == OP_TOG) ? ~outs_q[osel] : dato;
        end
    end

    logic [AW-1:0] next_adr;
    logic [AW-1:0] pc_q;

`ifdef ONEBC_SEQ_STACK_EN
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  stk_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [SPW-1:0] sp_m1;
    logic           ovf_q;
    logic           ovf_d;
    logic           unf_q;
    logic           unf_d;
    logic           push;
    logic           full;
    logic           empty;

    assign sp_m1 = sp_q - SPW'(1);
    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);

    always_comb begin
        next_adr = dati ? tadr : fadr;
        sp_d     = sp_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push     = 1'b0;
        case (op)
            OP_CALL: begin
                // A full stack drops the return address but still takes the jump.
                next_adr = tadr;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp_q + SPW'(1);
                end
            end
            OP_RET: begin
                if (empty) begin
                    next_adr = fadr;
                    unf_d    = 1'b1;
                end else begin
                    next_adr = stk_q[sp_m1[PW-1:0]];
                    sp_d     = sp_m1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (en_i) begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entries above sp are dead, so the storage itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (en_i && push) begin
            stk_q[sp_q[PW-1:0]] <= fadr;
        end
    end

    assign sp_o  = sp_q;
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
`else
    // Without the stack, CALL and RET branch exactly like BRANCH.
    always_comb begin
        next_adr = dati ? tadr : fadr;
    end

    assign sp_o  = '0;
    assign ovf_o = 1'b0;
    assign unf_o = 1'b0;
`endif

    assign imem_adr_o = !arst_ni ? '0 : (!en_i ? pc_q : next_adr);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pc_q   <= '0;
            outs_q <= '0;
        end else begin
            pc_q <= imem_adr_o;
            if (en_i) begin
                outs_q <= outs_d;
            end
        end
    end

    assign outs_o = outs_q;

endmodule

// File: tb/tb_onebc_seq.sv
// Directed bench for onebc_seq with a queue-based reference model checked every cycle.
module tb_onebc_seq;
    localparam int N_IN = 8, N_OUT = 8, AW = 8, DEPTH = 4;
    localparam int SPW = 3, IW = 25;
`ifdef ONEBC_SEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic             clk_i   = 1'b0;
    logic             arst_ni = 1'b0;
    logic             en_i    = 1'b1;
    logic [N_IN-1:0]  ins_i   = '0;
    logic [N_OUT-1:0] outs_o;
    logic [AW-1:0]    imem_adr_o;
    logic [IW-1:0]    imem_dat_i;
    logic [SPW-1:0]   sp_o;
    logic             ovf_o;
    logic             unf_o;

    onebc_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .en_i       (en_i),
        .ins_i      (ins_i),
        .outs_o     (outs_o),
        .imem_adr_o (imem_adr_o),
        .imem_dat_i (imem_dat_i),
        .sp_o       (sp_o),
        .ovf_o      (ovf_o),
        .unf_o      (unf_o)
    );

    always #5 clk_i = ~clk_i;

    logic [IW-1:0] mem [256];
    always @(posedge clk_i) imem_dat_i <= mem[imem_adr_o];

    int vecs = 0;
    int miss = 0;
    bit run  = 1'b0;

    // Reference state: output word, return stack as a queue, sticky flags, current pc.
    int m_outs = 0;
    int m_stk[$];
    int m_ovf = 0;
    int m_unf = 0;
    int m_pc  = 0;
    int s_nxt, s_w, s_op, s_dato, s_osel, s_fadr;

    function automatic logic [IW-1:0] mk(int op, int dato, int osel, int isel, int tadr, int fadr);
        return IW'(((((op * 2 + dato) * 8 + osel) * 8 + isel) * 256 + tadr) * 256 + fadr);
    endfunction

    function automatic int model_next();
        int w, op, isel, tadr, fadr, dati;
        w    = int'(mem[m_pc]);
        op   = w >> 23;
        isel = (w >> 16) % 8;
        tadr = (w >> 8) % 256;
        fadr = w % 256;
        dati = (isel < N_IN) ? int'(ins_i[isel]) : 0;
        if (!STK && (op == 1 || op == 2)) op = 0;
        case (op)
            1:       return tadr;
            2:       return (m_stk.size() == 0) ? fadr : m_stk[$];
            default: return (dati != 0) ? tadr : fadr;
        endcase
    endfunction

    function automatic int exp_adr();
        if (!arst_ni) return 0;
        if (!en_i) return m_pc;
        return model_next();
    endfunction

    always @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            m_outs = 0;
            m_stk.delete();
            m_ovf  = 0;
            m_unf  = 0;
            m_pc   = 0;
        end else if (en_i) begin
            s_nxt  = model_next();
            s_w    = int'(mem[m_pc]);
            s_op   = s_w >> 23;
            s_dato = (s_w >> 22) % 2;
            s_osel = (s_w >> 19) % 8;
            s_fadr = s_w % 256;
            if (s_osel < N_OUT) begin
                if (s_op == 3) m_outs = m_outs ^ (1 << s_osel);
                else           m_outs = (m_outs & ~(1 << s_osel)) | (s_dato << s_osel);
            end
            if (STK && s_op == 1) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else                       m_stk.push_back(s_fadr);
            end
            if (STK && s_op == 2) begin
                if (m_stk.size() == 0) m_unf = 1;
                else                   void'(m_stk.pop_back());
            end
            m_pc = s_nxt;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (run) begin
            cmp("model_outs", 32'(outs_o), m_outs);
            cmp("model_adr",  32'(imem_adr_o), exp_adr());
            cmp("model_sp",   32'(sp_o), m_stk.size());
            cmp("model_ovf",  32'(ovf_o), m_ovf);
            cmp("model_unf",  32'(unf_o), m_unf);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_test(input logic [7:0] ins);
        arst_ni = 1'b0;
        en_i    = 1'b1;
        ins_i   = ins;
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic release_rst();
        tick();
        tick();
        arst_ni = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state and taken branch.
        start_test(8'h04);
        mem[0] = mk(0, 1, 3, 2, 'h10, 'h20);
        tick();
        run = 1'b1;
        tick();
        cmp("rst_outs", 32'(outs_o), 0);
        cmp("rst_adr",  32'(imem_adr_o), 0);
        cmp("rst_sp",   32'(sp_o), 0);
        cmp("rst_ovf",  32'(ovf_o), 0);
        cmp("rst_unf",  32'(unf_o), 0);
        release_rst();
        cmp("br_taken_adr", 32'(imem_adr_o), 'h10);
        tick();
        cmp("br_outs", 32'(outs_o), 'h08);
        en_i = 1'b0;
        #1;
        cmp("br_pc", 32'(imem_adr_o), 'h10);
        en_i = 1'b1;

        // Not-taken branch, then two toggles of bit 3.
        start_test(8'h00);
        mem[0]     = mk(0, 1, 3, 2, 'h10, 'h20);
        mem['h20]  = mk(3, 0, 3, 0, 'h21, 'h21);
        mem['h21]  = mk(3, 1, 3, 0, 'h22, 'h22);
        mem['h22]  = mk(0, 0, 7, 0, 'h22, 'h22);
        release_rst();
        cmp("br_ntaken_adr", 32'(imem_adr_o), 'h20);
        tick();
        cmp("ntaken_outs", 32'(outs_o), 'h08);
        tick();
        cmp("tog1_outs", 32'(outs_o), 'h00);
        tick();
        cmp("tog2_outs", 32'(outs_o), 'h08);

        // Call and return.
        start_test(8'h00);
        mem[0]    = mk(1, 0, 0, 0, 'h40, 'h05);
        mem['h40] = mk(2, 1, 1, 0, 'h41, 'h42);
        mem[5]    = mk(0, 0, 2, 0, 'h05, 'h05);
        release_rst();
        cmp("call_adr", 32'(imem_adr_o), STK ? 'h40 : 'h05);
        tick();
        cmp("call_sp",  32'(sp_o), STK ? 1 : 0);
        cmp("ret_adr",  32'(imem_adr_o), 'h05);
        tick();
        cmp("ret_sp",   32'(sp_o), 0);
        cmp("ret_outs", 32'(outs_o), STK ? 'h02 : 'h00);

        // Five nested calls overflow a 4-deep stack.
        start_test(8'h00);
        for (int i = 0; i < 4; i++) mem[i] = mk(1, 0, 0, 0, i + 1, 'h70 + i);
        mem[4]    = mk(1, 0, 0, 0, 'h50, 'h74);
        mem['h50] = mk(0, 0, 0, 0, 'h50, 'h50);
        release_rst();
        repeat (4) tick();
        cmp("ovf_sp4",   32'(sp_o), STK ? 4 : 0);
        cmp("ovf_pre",   32'(ovf_o), 0);
        cmp("ovf_jump",  32'(imem_adr_o), STK ? 'h50 : 'h70);
        tick();
        cmp("ovf_sp",    32'(sp_o), STK ? 4 : 0);
        cmp("ovf_flag",  32'(ovf_o), STK ? 1 : 0);

        // Return on an empty stack.
        start_test(8'h00);
        mem[0] = mk(2, 0, 0, 0, 'h34, 'h33);
        release_rst();
        cmp("unf_adr",  32'(imem_adr_o), 'h33);
        tick();
        cmp("unf_flag", 32'(unf_o), STK ? 1 : 0);
        cmp("unf_sp",   32'(sp_o), 0);

        // Stall for three clocks on a CALL.
        start_test(8'h00);
        mem[0]    = mk(0, 1, 5, 0, 'h08, 'h08);
        mem[8]    = mk(1, 1, 6, 0, 'h40, 'h09);
        mem['h40] = mk(0, 0, 7, 0, 'h40, 'h40);
        release_rst();
        tick();
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp("stall_adr",  32'(imem_adr_o), 'h08);
            cmp("stall_outs", 32'(outs_o), 'h20);
            cmp("stall_sp",   32'(sp_o), 0);
            tick();
        end
        en_i = 1'b1;
        #1;
        cmp("resume_adr", 32'(imem_adr_o), STK ? 'h40 : 'h09);
        tick();
        cmp("resume_outs", 32'(outs_o), 'h60);
        cmp("resume_sp",   32'(sp_o), STK ? 1 : 0);

        // Asynchronous reset between edges.
        start_test(8'h01);
        mem[0] = mk(1, 1, 0, 0, 1, 'h10);
        mem[1] = mk(1, 1, 2, 0, 2, 'h11);
        mem[2] = mk(0, 1, 5, 0, 3, 3);
        mem[3] = mk(0, 1, 7, 0, 3, 3);
        release_rst();
        repeat (4) tick();
        cmp("pre_arst_outs", 32'(outs_o), 'hA5);
        cmp("pre_arst_sp",   32'(sp_o), STK ? 2 : 0);
        #5;
        arst_ni = 1'b0;
        #1;
        cmp("arst_outs", 32'(outs_o), 0);
        cmp("arst_sp",   32'(sp_o), 0);
        cmp("arst_adr",  32'(imem_adr_o), 0);
        cmp("arst_ovf",  32'(ovf_o), 0);
        tick();
        run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/onebc_seq.md
# onebc_seq

Parametrised successor of the 1-bit computer: a ROM-driven bit sequencer that tests one selected input bit per instruction, writes one output bit, and branches to one of two addresses. New over the fixed 8/8/256 machine: configurable input, output and address widths; a call/return stack; a toggle opcode; a stall input; and sticky stack-error flags. It sits between an external synchronous-read instruction memory and the board-level input/output pins.

## Interface
- N_IN, 8: number of input bits; ISW = max(1, $clog2(N_IN)).
- N_OUT, 8: number of output bits; OSW = max(1, $clog2(N_OUT)).
- AW, 8: instruction address width.
- DEPTH, 4: return-stack entries, at least 1; SPW = $clog2(DEPTH+1).
- IW (derived, not overridable): 3 + OSW + ISW + 2*AW.
- clk_i  input  1  single clock; all state updates on the rising edge.
- arst_ni  input  1  asynchronous, active-low reset.
- en_i  input  1  execute enable; 0 stalls the sequencer.
- ins_i  input  N_IN  condition inputs, sampled combinationally.
- outs_o  output  N_OUT  registered output bits.
- imem_adr_o  output  AW  fetch address to the instruction memory.
- imem_dat_i  input  IW  instruction; the memory registers the address on the rising edge, one-cycle read latency.
- sp_o  output  SPW  current stack occupancy, 0..DEPTH.
- ovf_o  output  1  sticky: CALL attempted while the stack was full.
- unf_o  output  1  sticky: RET attempted while the stack was empty.

## Operation
- Instruction fields, MSB to LSB: op[1:0], dato, osel[OSW], isel[ISW], tadr[AW], fadr[AW].
- dati = ins_i[isel]. If isel >= N_IN, dati = 0. If osel >= N_OUT, no output bit is written.
- op 00 BRANCH: outs[osel] <= dato; next = dati ? tadr : fadr.
- op 01 CALL: outs[osel] <= dato; push fadr; next = tadr, regardless of dati. If the stack is full, the push is dropped, ovf_o is set to 1, and the jump to tadr still happens.
- op 10 RET: outs[osel] <= dato; next = top of stack, then pop. If the stack is empty, next = fadr and unf_o is set to 1.
- op 11 TOGGLE: outs[osel] <= ~outs[osel]; dato is ignored; next = dati ? tadr : fadr.
- pc_q is an internal register holding the address of the instruction currently on imem_dat_i. It loads imem_adr_o on every rising edge.
- imem_adr_o (combinational):
  - 0 while arst_ni = 0;
  - otherwise pc_q while en_i = 0;
  - otherwise next.
- Stall (en_i = 0): no update to outs, the stack, sp_o or the flags. The memory re-fetches the same instruction, so execution resumes exactly where it stopped.
- ovf_o and unf_o clear only on reset.

## Timing
- Reset (arst_ni = 0), applied asynchronously:
  - outs_o = 0, sp_o = 0, ovf_o = 0, unf_o = 0, pc_q = 0;
  - imem_adr_o = 0.
- Throughput is one instruction per clock while en_i = 1.
- The first instruction executed after reset release is at address 0. The memory has already registered address 0 during reset.
- Output latency: a write to outs_o is visible immediately after the rising edge that ends the instruction's cycle.
- ins_i must be stable for the setup time before the rising edge. The path ins_i -> imem_adr_o is combinational.
- Reset asserted mid-stall or mid-call: all state is cleared and the stack contents are discarded.
- RET with DEPTH entries in use, then CALL in the next instruction: the push succeeds (sp goes DEPTH-1 then DEPTH).

## Configuration
- ONEBC_SEQ_STACK_EN defined: CALL and RET behave as above.
- ONEBC_SEQ_STACK_EN not defined:
  - the stack is not built;
  - CALL and RET decode as BRANCH;
  - sp_o, ovf_o and unf_o are tied to 0.

## Test plan
- Reset and branch: reset, mem[0] = BRANCH dato=1 osel=3 isel=2 tadr=0x10 fadr=0x20, ins_i = 0x04 -> outs_o = 0x08, imem_adr_o = 0x10 after one clock.
- Not-taken path and toggle: ins_i = 0x00 at the same instruction -> imem_adr_o = 0x20. Then TOGGLE osel=3 twice -> outs_o bit 3 reads 0, then 1.
- Call/return: CALL tadr=0x40 fadr=0x05, subroutine at 0x40 = RET -> sp_o goes 0 -> 1 -> 0, and the fetch sequence is 0x40 then 0x05.
- Overflow and underflow with DEPTH = 4:
  - five nested CALLs -> sp_o = 4, ovf_o = 1, the fifth jump is still taken;
  - RET with sp_o = 0 and fadr = 0x33 -> next fetch is 0x33, unf_o = 1.
- Stall: hold en_i = 0 for 3 clocks during a CALL -> imem_adr_o stays at pc_q, outs_o and sp_o are unchanged, and the CALL executes on the first edge with en_i = 1.
- Async reset mid-run: drop arst_ni between edges after outs_o = 0xA5 and sp_o = 2 -> outs_o = 0, sp_o = 0, imem_adr_o = 0 before the next edge. Repeat with ONEBC_SEQ_STACK_EN undefined -> CALL behaves as BRANCH and sp_o stays 0.
